// File: rtl/rr_arb32_if.sv
// rtl/rr_arb32_if.sv - request/grant bundle between the requester bank and rr_arb32
//
// Signals:
//   i_req        [31:0] request vector, bit n = requester n wants the resource
//   i_release           single-cycle release pulse from the current owner
//   o_gnt_valid         a grant is active
//   o_gnt_idx    [4:0]  owner index, drives the shared 32:1 mux select
//   o_gnt_onehot [31:0] one-hot copy of o_gnt_idx, zero while no grant
//   o_timeout           one-cycle pulse when the hold watchdog forces a release
// Modports:
//   master - arbiter side (drives the grant outputs)
//   slave  - requester side (drives requests and release)
interface rr_arb32_if;
  logic [31:0] i_req;
  logic        i_release;
  logic        o_gnt_valid;
  logic [4:0]  o_gnt_idx;
  logic [31:0] o_gnt_onehot;
  logic        o_timeout;

  modport master (
    input  i_req,
    input  i_release,
    output o_gnt_valid,
    output o_gnt_idx,
    output o_gnt_onehot,
    output o_timeout
  );

  modport slave (
    output i_req,
    output i_release,
    input  o_gnt_valid,
    input  o_gnt_idx,
    input  o_gnt_onehot,
    input  o_timeout
  );
endinterface

// File: rtl/rr_arb32.sv
// rtl/rr_arb32.sv - 32-way round-robin arbiter with held grants and registered mux select
//
// Purpose: grants one of 32 requesters ownership of a shared resource, holds
// the grant until the owner releases it or drops its request, then moves the
// priority pointer just past the last owner. All outputs are registered.
// Optional feature macro: RR_ARB32_TIMEOUT_EN builds a hold watchdog that
// force-releases a grant after TIMEOUT cycles and pulses o_timeout.
//
// Parameters:
//   TIMEOUT   maximum grant hold in cycles (1..65535), watchdog build only
// Ports:
//   i_clk     clock, rising edge
//   i_reset   synchronous active-high reset
//   bus       rr_arb32_if.master (i_req, i_release, o_gnt_valid, o_gnt_idx,
//             o_gnt_onehot, o_timeout)
module rr_arb32 #(
  parameter int TIMEOUT = 255
) (
  input  logic         i_clk,
  input  logic         i_reset,
  rr_arb32_if.master   bus
);

  if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_timeout
    $error("rr_arb32: TIMEOUT must be in 1..65535");
  end

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_GRANT = 1'b1
  } state_t;

  state_t      r_state;
  logic [4:0]  r_ptr;
  logic [4:0]  r_gnt_idx;
  logic        r_gnt_valid;
  logic [31:0] r_gnt_onehot;

  logic        w_found;
  logic [4:0]  w_winner;
  logic        w_rel_exit;
  logic        w_wd_expire;

  // Rotating priority scan. Walking the offsets from farthest to nearest
  // means the last hit written is the one closest to r_ptr.
  always_comb begin : p_winner
    logic [4:0] v_cand;
    v_cand   = 5'd0;
    w_winner = r_ptr;
    w_found  = |bus.i_req;
    for (int i = 31; i >= 0; i--) begin
      v_cand = r_ptr + 5'(i);
      if (bus.i_req[v_cand]) begin
        w_winner = v_cand;
      end
    end
  end

  // Owner-driven exit: explicit release or the owner dropping its request.
  // Both together are still one release.
  assign w_rel_exit = bus.i_release | ~bus.i_req[r_gnt_idx];

`ifdef RR_ARB32_TIMEOUT_EN
  localparam logic [15:0] LP_HOLD_LAST = 16'(TIMEOUT - 1);

  logic [15:0] r_hold_cnt;
  logic        r_timeout;

  assign w_wd_expire = (r_hold_cnt == LP_HOLD_LAST);

  // Counter sits at zero in IDLE so it is already cleared on the entry edge.
  // The timeout pulse is only raised when the watchdog is the sole reason
  // for leaving GRANT; a coincident owner release wins.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_hold_cnt <= 16'd0;
      r_timeout  <= 1'b0;
    end else begin
      r_timeout <= (r_state == S_GRANT) & w_wd_expire & ~w_rel_exit;
      if (r_state == S_IDLE) begin
        r_hold_cnt <= 16'd0;
      end else begin
        r_hold_cnt <= r_hold_cnt + 16'd1;
      end
    end
  end

  assign bus.o_timeout = r_timeout;
`else
  assign w_wd_expire   = 1'b0;
  assign bus.o_timeout = 1'b0;
`endif

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state      <= S_IDLE;
      r_ptr        <= 5'd0;
      r_gnt_idx    <= 5'd0;
      r_gnt_valid  <= 1'b0;
      r_gnt_onehot <= 32'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_gnt_idx    <= w_winner;
            r_gnt_valid  <= 1'b1;
            r_gnt_onehot <= 32'd1 << w_winner;
            r_state      <= S_GRANT;
          end
        end
        S_GRANT: begin
          // r_gnt_idx stays at the last owner after exit; consumers
          // qualify it with o_gnt_valid.
          if (w_rel_exit || w_wd_expire) begin
            r_gnt_valid  <= 1'b0;
            r_gnt_onehot <= 32'd0;
            r_ptr        <= r_gnt_idx + 5'd1;
            r_state      <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.o_gnt_valid  = r_gnt_valid;
  assign bus.o_gnt_idx    = r_gnt_idx;
  assign bus.o_gnt_onehot = r_gnt_onehot;

endmodule

// File: tb/tb_rr_arb32.sv
// tb/tb_rr_arb32.sv - directed self-checking bench for rr_arb32
module tb_rr_arb32;
  logic clk = 1'b0;
  logic rst;
  int   n_total = 0;
  int   n_bad   = 0;

  rr_arb32_if bus ();

  always #5 clk = ~clk;

  rr_arb32 #(.TIMEOUT(4)) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_gnt(input string tag, input int idx);
    logic [31:0] oh;
    oh = 32'd1 << idx;
    chk({tag, "_valid"}, {31'd0, bus.o_gnt_valid}, 32'd1);
    chk({tag, "_idx"}, {27'd0, bus.o_gnt_idx}, 32'(idx));
    chk({tag, "_onehot"}, bus.o_gnt_onehot, oh);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_valid"}, {31'd0, bus.o_gnt_valid}, 32'd0);
    chk({tag, "_onehot"}, bus.o_gnt_onehot, 32'd0);
  endtask

  task automatic release_pulse();
    bus.i_release = 1'b1;
    tick();
    bus.i_release = 1'b0;
  endtask

  initial begin
    int exp_seq[5];
    logic held;
    logic to_seen;
    exp_seq = '{0, 1, 4, 0, 1};

    // Reset with all requests high: outputs quiet, then grant 0.
    rst           = 1'b1;
    bus.i_req     = 32'hFFFF_FFFF;
    bus.i_release = 1'b0;
    tick();
    tick();
    chk_idle("rst");
    chk("rst_idx", {27'd0, bus.o_gnt_idx}, 32'd0);
    chk("rst_timeout", {31'd0, bus.o_timeout}, 32'd0);
    rst = 1'b0;
    tick();
    chk_gnt("rst_first", 0);

    // Rotation over {0,1,4} from ptr=0 with one bubble between owners.
    rst       = 1'b1;
    bus.i_req = 32'h0000_0013;
    tick();
    rst = 1'b0;
    chk_idle("rst_mid_first");
    tick();
    for (int i = 0; i < 5; i++) begin
      chk_gnt($sformatf("rot%0d", i), exp_seq[i]);
      release_pulse();
      chk_idle($sformatf("rot%0d_bubble", i));
      if (i < 4) tick();
    end
    bus.i_req = 32'd0;
    tick();
    chk_idle("rot_quiet");

    // ptr=2: owner 30, then wrap through 31 to 2.
    bus.i_req = 32'h4000_0000;
    tick();
    chk_gnt("own30", 30);
    bus.i_req = 32'h8000_0004;
    release_pulse();
    chk_idle("own30_rel");
    tick();
    chk_gnt("wrap31", 31);
    release_pulse();
    chk_idle("wrap31_rel");
    tick();
    chk_gnt("wrap2", 2);
    bus.i_req = 32'd0;
    release_pulse();
    chk_idle("wrap2_rel");

    // ptr=3: owner 5 drops its request, next among {3,7} is 7.
    bus.i_req = 32'h0000_0020;
    tick();
    chk_gnt("own5", 5);
    bus.i_req = 32'h0000_0088;
    tick();
    chk_idle("drop");
    chk("drop_idx_hold", {27'd0, bus.o_gnt_idx}, 32'd5);
    tick();
    chk_gnt("drop_next", 7);
    bus.i_req = 32'd0;
    release_pulse();

    // Release while idle is ignored.
    release_pulse();
    chk_idle("idle_rel");

    // ptr=8: owner 12, reset mid-grant sends ptr back to 0.
    bus.i_req = 32'h0000_1000;
    tick();
    chk_gnt("own12", 12);
    rst       = 1'b1;
    bus.i_req = 32'h0000_1001;
    tick();
    rst = 1'b0;
    chk_idle("rst_grant");
    chk("rst_grant_idx", {27'd0, bus.o_gnt_idx}, 32'd0);
    chk("rst_grant_timeout", {31'd0, bus.o_timeout}, 32'd0);
    tick();
    chk_gnt("post_rst", 0);
    bus.i_req = 32'd0;
    release_pulse();

    // Watchdog case: owner 9 never releases.
    bus.i_req = 32'h0000_0200;
    tick();
    chk_gnt("wd_gnt", 9);
`ifdef RR_ARB32_TIMEOUT_EN
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("wd_hold%0d", i), {31'd0, bus.o_gnt_valid}, 32'd1);
      chk($sformatf("wd_hold%0d_to", i), {31'd0, bus.o_timeout}, 32'd0);
    end
    tick();
    chk_idle("wd_drop");
    chk("wd_pulse", {31'd0, bus.o_timeout}, 32'd1);
    tick();
    chk("wd_pulse_end", {31'd0, bus.o_timeout}, 32'd0);
    chk_gnt("wd_regrant", 9);
    for (int i = 0; i < 3; i++) tick();
    chk("wd_pre_rel", {31'd0, bus.o_gnt_valid}, 32'd1);
    release_pulse();
    chk_idle("wd_and_rel");
    chk("wd_and_rel_to", {31'd0, bus.o_timeout}, 32'd0);
`else
    held    = 1'b1;
    to_seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (bus.o_gnt_valid !== 1'b1 || bus.o_gnt_idx !== 5'd9) held = 1'b0;
      if (bus.o_timeout !== 1'b0) to_seen = 1'b1;
    end
    chk("nowd_held", {31'd0, held}, 32'd1);
    chk("nowd_timeout", {31'd0, to_seen}, 32'd0);
    release_pulse();
    chk_idle("nowd_rel");
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
